// File: rtl/mmio_pkg.sv
// ---------------------------------------------------------------------------
// mmio_pkg : default geometry and scan FSM states for the MMIO data memory.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package mmio_pkg;

  localparam int DATA_W_DEF       = 16;
  localparam int ADDR_W_DEF       = 15;
  localparam int RAM_WORDS_DEF    = 16384;
  localparam int SCREEN_WORDS_DEF = 8192;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } scan_state_e;

endpackage

`default_nettype wire

// File: rtl/mmio_dpram.sv
// ---------------------------------------------------------------------------
// mmio_dpram : dual-port RAM, port A read/write, port B read-only, both
// read-before-write with one cycle latency. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mmio_dpram #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 15,
  parameter int DEPTH  = 24576
) (
  input  logic              clk,
  input  logic              we_a_i,
  input  logic [ADDR_W-1:0] addr_a_i,
  input  logic [DATA_W-1:0] wdata_a_i,
  output logic [DATA_W-1:0] rdata_a_o,
  input  logic              en_b_i,
  input  logic [ADDR_W-1:0] addr_b_i,
  output logic [DATA_W-1:0] rdata_b_o
);

  logic [DATA_W-1:0] mem_q [0:DEPTH-1];

  // Both reads sample the array before the port A write lands.
  always_ff @(posedge clk) begin
    rdata_a_o <= mem_q[addr_a_i];
    if (en_b_i) begin
      rdata_b_o <= mem_q[addr_b_i];
    end
    if (we_a_i) begin
      mem_q[addr_a_i] <= wdata_a_i;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mmio_data_memory.sv
// ---------------------------------------------------------------------------
// mmio_data_memory : CPU RAM + framebuffer + keyboard register, with optional
// framebuffer scan-out stream enabled by MMIO_DATA_MEMORY_SCAN_EN. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mmio_data_memory
  import mmio_pkg::*;
#(
  parameter int DATA_W       = DATA_W_DEF,
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int RAM_WORDS    = RAM_WORDS_DEF,
  parameter int SCREEN_WORDS = SCREEN_WORDS_DEF,
  parameter int KBD_ADDR     = RAM_WORDS + SCREEN_WORDS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [ADDR_W-1:0] adr,
  input  logic [DATA_W-1:0] d_in,
  output logic [DATA_W-1:0] d_out,
  input  logic [DATA_W-1:0] kb_in,
  output logic              scan_valid,
  input  logic              scan_ready,
  output logic [DATA_W-1:0] scan_data,
  output logic              scan_sof
);

  localparam int DEPTH  = RAM_WORDS + SCREEN_WORDS;
  localparam int SCAN_W = (SCREEN_WORDS > 1) ? $clog2(SCREEN_WORDS) : 1;
  localparam logic [ADDR_W:0]   DEPTH_A = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] KBD_A   = ADDR_W'(KBD_ADDR);
  localparam logic [ADDR_W-1:0] FB_BASE = ADDR_W'(RAM_WORDS);

  logic              adr_kbd_w;
  logic              adr_mem_w;
  logic              we_w;
  logic [DATA_W-1:0] rdata_a_w;
  logic [DATA_W-1:0] rdata_b_w;
  logic              en_b_w;
  logic [ADDR_W-1:0] addr_b_w;

  logic [DATA_W-1:0] sync1_q;
  logic [DATA_W-1:0] kbd_q;
  logic              mem_sel_q;
  logic [DATA_W-1:0] kbd_rd_q;

  assign adr_kbd_w = (adr == KBD_A);
  assign adr_mem_w = ({1'b0, adr} < DEPTH_A) && !adr_kbd_w;
  assign we_w      = load && adr_mem_w;

  mmio_dpram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_dpram (
    .clk       (clk),
    .we_a_i    (we_w),
    .addr_a_i  (adr),
    .wdata_a_i (d_in),
    .rdata_a_o (rdata_a_w),
    .en_b_i    (en_b_w),
    .addr_b_i  (addr_b_w),
    .rdata_b_o (rdata_b_w)
  );

  // The keyboard read value is captured alongside the RAM read so both
  // paths share the same one-cycle latency; unmapped reads resolve to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= '0;
      kbd_q     <= '0;
      mem_sel_q <= 1'b0;
      kbd_rd_q  <= '0;
    end else begin
      sync1_q   <= kb_in;
      kbd_q     <= sync1_q;
      mem_sel_q <= adr_mem_w;
      kbd_rd_q  <= adr_kbd_w ? kbd_q : '0;
    end
  end

  assign d_out = mem_sel_q ? rdata_a_w : kbd_rd_q;

`ifdef MMIO_DATA_MEMORY_SCAN_EN
  scan_state_e       state_q, state_d;
  logic [SCAN_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Port B fetches the word for cnt_d, so it is on rdata_b when cnt_q gets there.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    en_b_w  = 1'b0;
    case (state_q)
      IDLE: begin
        state_d = STREAM;
        cnt_d   = '0;
        en_b_w  = 1'b1;
      end
      STREAM: begin
        if (scan_ready) begin
          en_b_w = 1'b1;
          cnt_d  = (cnt_q == SCAN_W'(SCREEN_WORDS - 1)) ? '0 : cnt_q + SCAN_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign addr_b_w   = FB_BASE + ADDR_W'(cnt_d);
  assign scan_valid = (state_q == STREAM);
  assign scan_sof   = scan_valid && (cnt_q == '0);
  assign scan_data  = scan_valid ? rdata_b_w : '0;
`else
  logic unused_scan_w;

  assign en_b_w        = 1'b0;
  assign addr_b_w      = FB_BASE;
  assign scan_valid    = 1'b0;
  assign scan_sof      = 1'b0;
  assign scan_data     = '0;
  assign unused_scan_w = scan_ready ^ (^rdata_b_w);
`endif

endmodule

`default_nettype wire

// File: doc/mmio_data_memory.md
MMIO_DATA_MEMORY -- requirements
Module: mmio_data_memory

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning data word width.
REQ-002 SHALL have parameter ADDR_W, default 15, meaning CPU word-address width.
REQ-003 SHALL have parameter RAM_WORDS, default 16384, meaning general RAM words at addresses 0..RAM_WORDS-1.
REQ-004 SHALL have parameter SCREEN_WORDS, default 8192, meaning framebuffer words at RAM_WORDS..RAM_WORDS+SCREEN_WORDS-1.
REQ-005 SHALL have parameter KBD_ADDR, default RAM_WORDS+SCREEN_WORDS, meaning address of the read-only keyboard register.
REQ-006 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-007 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port load, input, 1, CPU write enable.
REQ-009 SHALL have port adr, input, ADDR_W, CPU word address.
REQ-010 SHALL have port d_in, input, DATA_W, CPU write data.
REQ-011 SHALL have port d_out, output, DATA_W, CPU read data, registered.
REQ-012 SHALL have port kb_in, input, DATA_W, asynchronous keyboard scancode.
REQ-013 SHALL have port scan_valid, output, 1, framebuffer stream word valid.
REQ-014 SHALL have port scan_ready, input, 1, display sink ready.
REQ-015 SHALL have port scan_data, output, DATA_W, framebuffer stream word.
REQ-016 SHALL have port scan_sof, output, 1, high with the word at framebuffer offset 0.

Function
REQ-017 SHALL write d_in to RAM or framebuffer at adr on a rising edge with load=1 when adr is in range.
REQ-018 SHALL drop writes to KBD_ADDR and to unmapped addresses, with no side effects.
REQ-019 SHALL present d_out one cycle after adr is sampled (read latency 1), every cycle, with no enable.
REQ-020 SHALL return 0 on d_out for unmapped addresses.
REQ-021 SHALL return the pre-write word on d_out for a read and write to the same address in one cycle (read-before-write).
REQ-022 SHALL pass kb_in through a two-flop synchronizer into the keyboard register; d_out at KBD_ADDR reflects the synchronized value.
REQ-023 SHALL hold a scan counter 0..SCREEN_WORDS-1 that advances only on scan_valid&&scan_ready.
REQ-024 SHALL wrap the scan counter from SCREEN_WORDS-1 to 0 and assert scan_sof with the offset-0 word.
REQ-025 SHALL hold scan_data, scan_sof and scan_valid stable while scan_valid=1 and scan_ready=0.
REQ-026 SHALL use a two-state scan FSM, IDLE then STREAM: IDLE→STREAM one cycle after reset release, with no return to IDLE except via reset.
REQ-027 SHALL keep scan_valid=1 continuously in STREAM, with a 1-cycle prefetch so the next word is ready on the handshake cycle (full throughput).
REQ-028 SHALL give scan_data the old word when a CPU write hits the framebuffer word being fetched in that same cycle.

Reset
REQ-029 SHALL, while rst_n=0, force d_out=0, scan_valid=0, scan_sof=0, scan_data=0, scan counter=0, FSM=IDLE, and synchronizer and keyboard register=0.
REQ-030 SHALL NOT clear RAM or framebuffer contents on reset.
REQ-031 SHALL restart the scan at offset 0 with scan_sof=1 when reset is asserted mid-frame.

Configuration
REQ-032 SHALL compile the scan-out port and FSM only when macro MMIO_DATA_MEMORY_SCAN_EN is defined.
REQ-033 SHALL, without MMIO_DATA_MEMORY_SCAN_EN, tie scan_valid, scan_sof and scan_data to 0, ignore scan_ready, and leave the CPU and keyboard behaviour unchanged.

Structure
REQ-034 SHALL place the default width/depth constants and the scan FSM state enum (IDLE, STREAM) in shared package mmio_pkg.
REQ-035 SHALL implement storage as one sub-module, mmio_dpram: a true dual-port RAM with port A for CPU read/write and port B for scan read-only, both read-before-write with 1-cycle latency.

Verification
REQ-036 SHALL verify: write 0x1234 to adr 5, then read adr 5 → d_out=0x1234 exactly one cycle after adr is applied.
REQ-037 SHALL verify: kb_in=0x0041 → d_out at adr 24576 reads 0x0041 within 3 cycles; write 0xFFFF to 24576 → still reads 0x0041.
REQ-038 SHALL verify: read of adr 24577 → d_out=0; write 0xBEEF to 24577 → no change to any mapped word.
REQ-039 SHALL verify: fill framebuffer with offset values, hold scan_ready=1 → 8192 words stream in order, scan_sof on words 0 and 8192, no bubbles.
REQ-040 SHALL verify: drop scan_ready for 5 cycles mid-frame → scan_data/scan_sof stable throughout, no word skipped or duplicated.
REQ-041 SHALL verify: assert rst_n=0 at scan offset 100, then release → first streamed word is offset 0 with scan_sof=1, and RAM contents are intact.
